// File: rtl/hc165_reader.sv
`default_nettype none
// ============================================================================
// Module   : hc165_reader
// Purpose  : Scan controller for a daisy chain of 74HC165 PISO shift
//            registers. Pulses PL_n to capture the parallel inputs, enables
//            the chain with CE_n, clocks N_BITS CP edges and assembles the
//            serial Q7 stream into one parallel word with a one-cycle strobe.
//
// Ports    : clk      in   system clock, rising edge
//            rst      in   synchronous active-high reset
//            start    in   scan request (honoured only when not scanning)
//            busy     out  high from first LOAD cycle through DONE cycle
//            data     out  [N_BITS] last completed scan word
//            valid    out  one-cycle pulse coincident with a data update
//            sr_pl_n  out  '165 PL_n (active-low parallel load)
//            sr_cp    out  '165 CP
//            sr_ce_n  out  '165 CE_n (active-low clock enable)
//            sr_q7    in   Q7 of the last '165 in the chain
//
// Options  : HC165_READER_AUTO_EN - when defined, the block rescans on its
//            own after T_GAP idle cycles (GAP state); start still works.
//
// Revision : 1.0 - initial release
// ============================================================================
module hc165_reader #(
    parameter int N_BITS = 16,   // chain length in bits, 2..32
    parameter int T_PL   = 2,    // PL_n low width in clk cycles, >= 1
    parameter int T_REC  = 2,    // PL_n rise to first CP rise, >= 1
    parameter int T_HALF = 1,    // CP half period in clk cycles, >= 1
    parameter int T_GAP  = 256   // idle cycles between automatic scans
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic [N_BITS-1:0] data,
    output logic              valid,
    output logic              sr_pl_n,
    output logic              sr_cp,
    output logic              sr_ce_n,
    input  logic              sr_q7
);

    // ------------------------------------------------------------------------
    // Counter sizing
    // ------------------------------------------------------------------------
    localparam int c_PH_MAX_A = (T_PL > T_REC) ? T_PL : T_REC;
    localparam int c_PH_MAX_B = (c_PH_MAX_A > T_HALF) ? c_PH_MAX_A : T_HALF;
    localparam int c_PH_MAX   = (c_PH_MAX_B > T_GAP) ? c_PH_MAX_B : T_GAP;
    localparam int c_PHASE_W  = $clog2(c_PH_MAX + 1);
    localparam int c_CNT_W    = $clog2(N_BITS + 1);

    // Phase counter reload values: each timed state counts down to zero,
    // so the reload is (duration - 1).
    localparam logic [c_PHASE_W-1:0] c_PL_LD   = c_PHASE_W'(T_PL - 1);
    localparam logic [c_PHASE_W-1:0] c_REC_LD  = c_PHASE_W'(T_REC - 1);
    localparam logic [c_PHASE_W-1:0] c_HALF_LD = c_PHASE_W'(T_HALF - 1);
    localparam logic [c_CNT_W-1:0]   c_CNT_LAST = c_CNT_W'(N_BITS);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    localparam logic [2:0] c_S_IDLE = 3'd0;
    localparam logic [2:0] c_S_LOAD = 3'd1;
    localparam logic [2:0] c_S_REC  = 3'd2;
    localparam logic [2:0] c_S_LO   = 3'd3;
    localparam logic [2:0] c_S_HI   = 3'd4;
    localparam logic [2:0] c_S_DONE = 3'd5;
`ifdef HC165_READER_AUTO_EN
    localparam logic [2:0]           c_S_GAP     = 3'd6;
    localparam logic [c_PHASE_W-1:0] c_GAP_LD    = c_PHASE_W'(T_GAP - 1);
    localparam logic [2:0]           c_RST_STATE = c_S_GAP;
    localparam logic [c_PHASE_W-1:0] c_RST_PHASE = c_GAP_LD;
`else
    localparam logic [2:0]           c_RST_STATE = c_S_IDLE;
    localparam logic [c_PHASE_W-1:0] c_RST_PHASE = '0;
`endif

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [2:0]           r_state;
    logic [c_PHASE_W-1:0] r_phase;
    logic [c_CNT_W-1:0]   r_bitcnt;
    logic [N_BITS-1:0]    r_sreg;
    logic [N_BITS-1:0]    r_data;
    logic                 r_busy;
    logic                 r_valid;
    logic                 r_pl_n;
    logic                 r_cp;
    logic                 r_ce_n;

    // ------------------------------------------------------------------------
    // Combinational next-state
    // ------------------------------------------------------------------------
    logic [2:0]           w_state_nxt;
    logic [c_PHASE_W-1:0] w_phase_nxt;
    logic                 w_phase_done;
    logic                 w_shift;
    logic                 w_busy_nxt;
    logic                 w_ce_n_nxt;

    assign w_phase_done = (r_phase == '0);

    always_comb begin
        w_state_nxt = r_state;
        w_phase_nxt = r_phase;
        w_shift     = 1'b0;
        case (r_state)
            c_S_IDLE: begin
                if (start) begin
                    w_state_nxt = c_S_LOAD;
                    w_phase_nxt = c_PL_LD;
                end
            end
            c_S_LOAD: begin
                if (w_phase_done) begin
                    w_state_nxt = c_S_REC;
                    w_phase_nxt = c_REC_LD;
                end else begin
                    w_phase_nxt = r_phase - 1'b1;
                end
            end
            c_S_REC: begin
                if (w_phase_done) begin
                    w_state_nxt = c_S_LO;
                    w_phase_nxt = c_HALF_LD;
                end else begin
                    w_phase_nxt = r_phase - 1'b1;
                end
            end
            c_S_LO: begin
                // Q7 has been stable for a full CP-low half period here;
                // capture it on the same edge that raises CP.
                if (w_phase_done) begin
                    w_shift     = 1'b1;
                    w_state_nxt = c_S_HI;
                    w_phase_nxt = c_HALF_LD;
                end else begin
                    w_phase_nxt = r_phase - 1'b1;
                end
            end
            c_S_HI: begin
                if (w_phase_done) begin
                    if (r_bitcnt == c_CNT_LAST) begin
                        w_state_nxt = c_S_DONE;
                    end else begin
                        w_state_nxt = c_S_LO;
                        w_phase_nxt = c_HALF_LD;
                    end
                end else begin
                    w_phase_nxt = r_phase - 1'b1;
                end
            end
            c_S_DONE: begin
`ifdef HC165_READER_AUTO_EN
                w_state_nxt = c_S_GAP;
                w_phase_nxt = c_GAP_LD;
`else
                w_state_nxt = c_S_IDLE;
                w_phase_nxt = '0;
`endif
            end
`ifdef HC165_READER_AUTO_EN
            c_S_GAP: begin
                if (start || w_phase_done) begin
                    w_state_nxt = c_S_LOAD;
                    w_phase_nxt = c_PL_LD;
                end else begin
                    w_phase_nxt = r_phase - 1'b1;
                end
            end
`endif
            default: begin
                w_state_nxt = c_RST_STATE;
                w_phase_nxt = c_RST_PHASE;
            end
        endcase
    end

    // Outputs are registered from the next state so that pin behaviour lines
    // up exactly with the state occupancy (no one-cycle decode lag).
    assign w_busy_nxt = (w_state_nxt == c_S_LOAD) || (w_state_nxt == c_S_REC) ||
                        (w_state_nxt == c_S_LO)   || (w_state_nxt == c_S_HI)  ||
                        (w_state_nxt == c_S_DONE);
    assign w_ce_n_nxt = !((w_state_nxt == c_S_REC) || (w_state_nxt == c_S_LO) ||
                          (w_state_nxt == c_S_HI));

    // ------------------------------------------------------------------------
    // Sequential logic
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= c_RST_STATE;
            r_phase  <= c_RST_PHASE;
            r_bitcnt <= '0;
            r_sreg   <= '0;
            r_busy   <= 1'b0;
            r_valid  <= 1'b0;
            r_pl_n   <= 1'b1;
            r_cp     <= 1'b0;
            r_ce_n   <= 1'b1;
            // A reset that aborts a scan keeps the last good word; a reset
            // applied while not scanning (power-up included) clears it.
            if (!r_busy) begin
                r_data <= '0;
            end
        end else begin
            r_state <= w_state_nxt;
            r_phase <= w_phase_nxt;
            r_busy  <= w_busy_nxt;
            r_valid <= (w_state_nxt == c_S_DONE);
            r_pl_n  <= (w_state_nxt != c_S_LOAD);
            r_cp    <= (w_state_nxt == c_S_HI);
            r_ce_n  <= w_ce_n_nxt;

            if (r_state == c_S_LOAD) begin
                r_bitcnt <= '0;
            end else if (w_shift) begin
                r_bitcnt <= r_bitcnt + 1'b1;
            end

            // First sampled bit ends up in the MSB after N_BITS shifts.
            if (w_shift) begin
                r_sreg <= {r_sreg[N_BITS-2:0], sr_q7};
            end

            if (w_state_nxt == c_S_DONE) begin
                r_data <= r_sreg;
            end
        end
    end

    assign busy    = r_busy;
    assign data    = r_data;
    assign valid   = r_valid;
    assign sr_pl_n = r_pl_n;
    assign sr_cp   = r_cp;
    assign sr_ce_n = r_ce_n;

endmodule
`default_nettype wire

// File: tb/tb_hc165_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_hc165_reader
// Purpose  : Self-checking bench for hc165_reader. Two chained '165 models
//            feed a default-parameter instance and a slow-timing instance.
//            Expected words and their valid cycles are queued at stimulus
//            time; monitors pop and compare on every valid pulse.
//            With HC165_READER_AUTO_EN defined the automatic-rescan timing
//            is checked instead of the start-driven scenarios.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hc165_reader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic rst, start, start2;
    logic [7:0] d_near, d_far;

    // default instance
    logic        busy, valid, pl_n, cp, ce_n, q7;
    logic [15:0] data;
    // slow-timing instance
    logic        busy2, valid2, pl_n2, cp2, ce_n2, q7_2;
    logic [15:0] data2;

    hc165_reader #(.N_BITS(16), .T_PL(2), .T_REC(2), .T_HALF(1), .T_GAP(10)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .data(data),
        .valid(valid), .sr_pl_n(pl_n), .sr_cp(cp), .sr_ce_n(ce_n), .sr_q7(q7)
    );

    hc165_reader #(.N_BITS(16), .T_PL(4), .T_REC(5), .T_HALF(3)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .busy(busy2), .data(data2),
        .valid(valid2), .sr_pl_n(pl_n2), .sr_cp(cp2), .sr_ce_n(ce_n2), .sr_q7(q7_2)
    );

    // ---------------- '165 chain models: {near chip, far chip} -------------
    logic [15:0] chain1, chain2;
    logic        cpm1 = 1'b0, cpm2 = 1'b0;
    always @(negedge clk) begin
        if (!pl_n) chain1 <= {d_near, d_far};
        else if (cp && !cpm1 && !ce_n) chain1 <= {chain1[14:0], 1'b0};
        cpm1 <= cp;
    end
    always @(negedge clk) begin
        if (!pl_n2) chain2 <= {d_near, d_far};
        else if (cp2 && !cpm2 && !ce_n2) chain2 <= {chain2[14:0], 1'b0};
        cpm2 <= cp2;
    end
    assign q7   = chain1[15];
    assign q7_2 = chain2[15];

    // ---------------- pin statistics, instance 1 ----------------------------
    int   cp_rises1 = 0, pl_run1 = 0, last_pl_run1 = 0, ce_low1 = 0, ce_bad1 = 0;
    int   busy_cnt1 = 0, valid_cnt1 = 0, pl_falls1 = 0, first_pl_fall1 = -1;
    logic cp_q1 = 1'b0;
    always @(negedge clk) begin
        if (cp && !cp_q1) cp_rises1 <= cp_rises1 + 1;
        cp_q1 <= cp;
        if (!pl_n) begin
            if (pl_run1 == 0) begin
                pl_falls1 <= pl_falls1 + 1;
                if (pl_falls1 == 0) first_pl_fall1 <= cyc;
            end
            pl_run1 <= pl_run1 + 1;
        end else if (pl_run1 != 0) begin
            last_pl_run1 <= pl_run1;
            pl_run1      <= 0;
        end
        if (!ce_n) ce_low1 <= ce_low1 + 1;
        if (!ce_n && (!busy || !pl_n || valid)) ce_bad1 <= ce_bad1 + 1;
        if (busy)  busy_cnt1  <= busy_cnt1 + 1;
        if (valid) valid_cnt1 <= valid_cnt1 + 1;
    end

    // ---------------- pin statistics, instance 2 ----------------------------
    int   cp_rises2 = 0, pl_run2 = 0, last_pl_run2 = 0, cp_run2 = 0;
    int   hi_min2 = 999, hi_max2 = 0, lo_min2 = 999, lo_max2 = 0;
    logic cp_q2 = 1'b0, seen_hi2 = 1'b0;
    always @(negedge clk) begin
        if (cp2 && !cp_q2) cp_rises2 <= cp_rises2 + 1;
        cp_q2 <= cp2;
        if (!pl_n2) begin
            pl_run2  <= pl_run2 + 1;
            hi_min2  <= 999; hi_max2 <= 0; lo_min2 <= 999; lo_max2 <= 0;
            seen_hi2 <= 1'b0;
            cp_run2  <= 1;
        end else begin
            if (pl_run2 != 0) begin
                last_pl_run2 <= pl_run2;
                pl_run2      <= 0;
            end
            if (cp2 != cp_q2) begin
                if (cp_q2) begin
                    if (cp_run2 < hi_min2) hi_min2 <= cp_run2;
                    if (cp_run2 > hi_max2) hi_max2 <= cp_run2;
                    seen_hi2 <= 1'b1;
                end else if (seen_hi2) begin
                    if (cp_run2 < lo_min2) lo_min2 <= cp_run2;
                    if (cp_run2 > lo_max2) lo_max2 <= cp_run2;
                end
                cp_run2 <= 1;
            end else begin
                cp_run2 <= cp_run2 + 1;
            end
        end
    end

    // ---------------- scoreboard --------------------------------------------
    int          n_checks = 0, n_fail = 0;
    int          exp_cyc1[$], exp_cyc2[$];
    logic [15:0] exp_dat1[$], exp_dat2[$];
    int          mon_c1, mon_c2;
    logic [15:0] mon_d1, mon_d2;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h (%0d), required 0x%0h (%0d)", name, act, act, req, req);
        end
    endtask

    initial forever begin
        @(negedge clk);
        if (valid) begin
            if (exp_cyc1.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_valid1: valid at cycle %0d, required none", cyc);
            end else begin
                mon_c1 = exp_cyc1.pop_front();
                mon_d1 = exp_dat1.pop_front();
                check("valid1_cycle", cyc, mon_c1);
                check("valid1_data", {16'h0, data}, {16'h0, mon_d1});
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (valid2) begin
            if (exp_cyc2.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_valid2: valid at cycle %0d, required none", cyc);
            end else begin
                mon_c2 = exp_cyc2.pop_front();
                mon_d2 = exp_dat2.pop_front();
                check("valid2_cycle", cyc, mon_c2);
                check("valid2_data", {16'h0, data2}, {16'h0, mon_d2});
            end
        end
    end

    // ---------------- stimulus helpers --------------------------------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_drain1(input int limit);
        int n = 0;
        while (exp_cyc1.size() != 0 && n < limit) begin
            tick(1);
            n++;
        end
        if (exp_cyc1.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain1_timeout: %0d valids pending, required 0", exp_cyc1.size());
            exp_cyc1.delete();
            exp_dat1.delete();
        end
    endtask

    task automatic wait_drain2(input int limit);
        int n = 0;
        while (exp_cyc2.size() != 0 && n < limit) begin
            tick(1);
            n++;
        end
        if (exp_cyc2.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain2_timeout: %0d valids pending, required 0", exp_cyc2.size());
            exp_cyc2.delete();
            exp_dat2.delete();
        end
    endtask

    // ---------------- main sequence -----------------------------------------
    int t, b_cp, b_ce, b_bad, b_busy, b_val, b_cp2, n;

    initial begin
        rst = 1'b1; start = 1'b0; start2 = 1'b0;
        d_near = 8'hAA; d_far = 8'h55;
        tick(3);
        rst = 1'b0;
        // reset state (registered during the reset cycles)
        check("rst_pl_n",  {31'h0, pl_n},  32'h1);
        check("rst_cp",    {31'h0, cp},    32'h0);
        check("rst_ce_n",  {31'h0, ce_n},  32'h1);
        check("rst_busy",  {31'h0, busy},  32'h0);
        check("rst_valid", {31'h0, valid}, 32'h0);
        check("rst_data",  {16'h0, data},  32'h0);

`ifdef HC165_READER_AUTO_EN
        // automatic rescans: LOAD 10 cycles after release, period 47
        t = cyc;
        exp_cyc1.push_back(t + 46); exp_dat1.push_back(16'hAA55);
        exp_cyc1.push_back(t + 93); exp_dat1.push_back(16'hAA55);
        tick(100);
        check("auto_first_load", first_pl_fall1, t + 10);
        check("auto_load_count", pl_falls1, 2);
        check("auto_valid_count", valid_cnt1, 2);
        check("auto_pending", exp_cyc1.size(), 0);
`else
        // --- single scan, with an ignored start while busy ---
        tick(2);
        b_cp = cp_rises1; b_ce = ce_low1; b_bad = ce_bad1; b_busy = busy_cnt1; b_val = valid_cnt1;
        t = cyc;
        start = 1'b1;
        exp_cyc1.push_back(t + 37); exp_dat1.push_back(16'hAA55);
        tick(1);
        start = 1'b0;
        tick(9);
        start = 1'b1;               // cycle t+10: busy, must be ignored
        tick(1);
        start = 1'b0;
        wait_drain1(60);
        tick(3);
        check("a_cp_rises", cp_rises1 - b_cp, 16);
        check("a_pl_low_width", last_pl_run1, 2);
        check("a_ce_low_cycles", ce_low1 - b_ce, 34);
        check("a_ce_outside_shift", ce_bad1 - b_bad, 0);
        check("a_busy_cycles", busy_cnt1 - b_busy, 37);
        check("a_valid_count", valid_cnt1 - b_val, 1);

        // --- start held high: back-to-back scans 38 cycles apart ---
        b_cp = cp_rises1; b_val = valid_cnt1; b_busy = busy_cnt1;
        t = cyc;
        start = 1'b1;
        exp_cyc1.push_back(t + 37); exp_dat1.push_back(16'hAA55);
        exp_cyc1.push_back(t + 75); exp_dat1.push_back(16'hF00F);
        tick(38);
        d_near = 8'hF0; d_far = 8'h0F;
        tick(37);
        start = 1'b0;               // cycle t+75 (DONE); next IDLE sees low
        wait_drain1(10);
        tick(40);
        check("b_cp_rises", cp_rises1 - b_cp, 32);
        check("b_valid_count", valid_cnt1 - b_val, 2);
        check("b_busy_cycles", busy_cnt1 - b_busy, 74);

        // --- reset after 5th CP rise aborts the scan ---
        d_near = 8'h3C; d_far = 8'hC3;
        b_cp = cp_rises1; b_val = valid_cnt1;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        n = 0;
        while (cp_rises1 - b_cp < 5 && n < 40) begin
            tick(1);
            n++;
        end
        check("c_reached_5_rises", cp_rises1 - b_cp, 5);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("c_abort_pl_n", {31'h0, pl_n}, 32'h1);
        check("c_abort_cp",   {31'h0, cp},   32'h0);
        check("c_abort_ce_n", {31'h0, ce_n}, 32'h1);
        check("c_abort_busy", {31'h0, busy}, 32'h0);
        check("c_abort_data", {16'h0, data}, 32'h0000F00F);
        tick(50);
        check("c_no_valid_after_abort", valid_cnt1 - b_val, 0);
        t = cyc;
        start = 1'b1;
        exp_cyc1.push_back(t + 37); exp_dat1.push_back(16'h3CC3);
        tick(1);
        start = 1'b0;
        wait_drain1(60);
        check("c_rescan_valid_count", valid_cnt1 - b_val, 1);

        // --- slow timing instance: T_PL=4, T_REC=5, T_HALF=3 ---
        b_cp2 = cp_rises2;
        t = cyc;
        start2 = 1'b1;
        exp_cyc2.push_back(t + 106); exp_dat2.push_back(16'h3CC3);
        tick(1);
        start2 = 1'b0;
        wait_drain2(130);
        tick(3);
        check("d_pl_low_width", last_pl_run2, 4);
        check("d_cp_high_min", hi_min2, 3);
        check("d_cp_high_max", hi_max2, 3);
        check("d_cp_low_min", lo_min2, 3);
        check("d_cp_low_max", lo_max2, 3);
        check("d_cp_rises", cp_rises2 - b_cp2, 16);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
